// File: rtl/sdm_pkg.sv
// ---------------------------------------------------------------------------
// sdm_pkg
// Shared definitions for the first-order sigma-delta modulator and its
// matching decimator.
//   SAMPLE_W            : sample width in bits
//   OSR_LO_DEF/OSR_HI_DEF: default frame lengths (clocks) for MODE=0/1
//   mode_e              : MODE encoding, identical on both ends of the link
//   hold_t              : 1-deep input holding register (flag + data)
//   osr_last()          : terminal count of the frame counter for a mode
// ---------------------------------------------------------------------------
package sdm_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int OSR_LO_DEF = 64;
    localparam int OSR_HI_DEF = 256;

    typedef enum logic [0:0] {
        MODE_OSR64  = 1'b0,
        MODE_OSR256 = 1'b1
    } mode_e;

    typedef struct packed {
        logic                full;
        logic [SAMPLE_W-1:0] data;
    } hold_t;

    // Last count of a frame: OSR-1 of whichever rate the mode selects.
    function automatic int osr_last(input mode_e mode, input int lo, input int hi);
        return (mode == MODE_OSR256) ? (hi - 1) : (lo - 1);
    endfunction

endpackage

// File: rtl/sdm_accum16.sv
// ---------------------------------------------------------------------------
// sdm_accum16
// First-order error-feedback accumulator. Every clock the current sample is
// added to the 16-bit residual; the carry out of that add is the next
// modulator bit. The residual is never cleared except by clr, so the
// fractional error carries across frames.
//   clk     : rising-edge clock
//   clr     : synchronous clear (residual and output bit to 0)
//   cur     : sample being modulated
//   bit_out : registered carry, the 1-bit pulse-density stream
// ---------------------------------------------------------------------------
module sdm_accum16
    import sdm_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic [SAMPLE_W-1:0] cur,
    output logic                bit_out
);

    logic [SAMPLE_W-1:0] acc;
    logic [SAMPLE_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, cur};

    always_ff @(posedge clk) begin
        if (clr) begin
            acc     <= '0;
            bit_out <= 1'b0;
        end else begin
            acc     <= sum[SAMPLE_W-1:0];
            bit_out <= sum[SAMPLE_W];
        end
    end

endmodule

// File: rtl/sigma_delta_modulator16bit.sv
// ---------------------------------------------------------------------------
// sigma_delta_modulator16bit
// Transmit end of the pulse-density link: takes 16-bit unsigned samples over
// a valid/ready handshake into a 1-deep holding register and modulates one
// sample per frame of OSR clocks. At each frame boundary the held sample
// becomes the current one; if nothing is held, the last sample repeats and
// UNDERFLOW pulses.
//   CLK       : system clock, rising edge
//   RST_N     : synchronous active-low reset
//   MODE      : OSR select (0 = OSR_LO, 1 = OSR_HI), latched at boundaries
//   DIN       : unsigned sample
//   DIN_VALID : DIN valid this cycle
//   DIN_READY : holding register empty (combinational from the flag)
//   VMOD      : registered modulator bitstream
//   FRAME_STB : high on the last clock of every frame
//   UNDERFLOW : high on a boundary clock that finds the holding register empty
// ---------------------------------------------------------------------------
module sigma_delta_modulator16bit
    import sdm_pkg::*;
#(
    parameter int OSR_LO = OSR_LO_DEF,
    parameter int OSR_HI = OSR_HI_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                MODE,
    input  logic [SAMPLE_W-1:0] DIN,
    input  logic                DIN_VALID,
    output logic                DIN_READY,
    output logic                VMOD,
    output logic                FRAME_STB,
    output logic                UNDERFLOW
);

    localparam int CNT_W = $clog2(OSR_HI);

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    last_cnt;
    mode_e               mode_q;
    hold_t               hold;
    logic [SAMPLE_W-1:0] cur;
    logic                boundary;
    logic                xfer;

    assign last_cnt  = CNT_W'(osr_last(mode_q, OSR_LO, OSR_HI));
    assign boundary  = (cnt == last_cnt);
    assign xfer      = DIN_VALID && !hold.full;

    assign DIN_READY = !hold.full;
    assign FRAME_STB = boundary;
    assign UNDERFLOW = boundary && !hold.full;

    // Frame counter and mode latch. The latch only reloads on the boundary
    // edge, so a MODE change mid-frame waits for the next frame.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt    <= '0;
            mode_q <= mode_e'(MODE);
        end else if (boundary) begin
            cnt    <= '0;
            mode_q <= mode_e'(MODE);
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

    // Holding register and current sample. A transfer needs an empty hold,
    // and a boundary load needs a full one, so the two never collide. A
    // sample taken on an empty boundary is not bypassed into cur; it waits
    // for the following boundary.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hold <= '0;
            cur  <= '0;
        end else if (boundary && hold.full) begin
            cur       <= hold.data;
            hold.full <= 1'b0;
        end else if (xfer) begin
            hold <= '{full: 1'b1, data: DIN};
        end
    end

    sdm_accum16 u_accum (
        .clk     (CLK),
        .clr     (!RST_N),
        .cur     (cur),
        .bit_out (VMOD)
    );

endmodule

// File: tb/tb_sigma_delta_modulator16bit.sv
module tb_sigma_delta_modulator16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        din_valid = 1'b0;
    logic        din_ready, vmod, frame_stb, underflow;

    always #5 clk = ~clk;

    sigma_delta_modulator16bit dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .MODE      (mode),
        .DIN       (din),
        .DIN_VALID (din_valid),
        .DIN_READY (din_ready),
        .VMOD      (vmod),
        .FRAME_STB (frame_stb),
        .UNDERFLOW (underflow)
    );

    int ntests = 0;
    int nfail  = 0;

    // Reference model: sample FIFO of depth 1, a frame position, and the
    // running sum of every sample value applied so far. The number of ones
    // emitted up to a clock is floor(running_sum / 65536), so each bit is
    // the step in that floor.
    logic [15:0]     m_hold[$];
    longint unsigned m_csum;
    longint unsigned m_cur;
    int              m_pos;
    logic            m_mode;
    logic            m_vmod;
    logic            m_valid = 1'b0;

    logic b2b = 1'b0;
    logic last_xfer;
    logic last_stb;
    int   cnt_ones, cnt_stb, cnt_uf, cnt_xfer;

    function automatic int frame_len(input logic md);
        return md ? 256 : 64;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ntests++;
        assert (obs === exp_v)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clr_counts();
        cnt_ones = 0; cnt_stb = 0; cnt_uf = 0; cnt_xfer = 0;
    endtask

    // One clock: check outputs against the model, advance the model with the
    // inputs presented this cycle, then cross the rising edge.
    task automatic cyc();
        longint unsigned nb;
        logic empty;
        empty = (m_hold.size() == 0);
        if (m_valid) begin
            chk("vmod",      vmod,      m_vmod);
            chk("din_ready", din_ready, empty);
            chk("frame_stb", frame_stb, m_pos == frame_len(m_mode) - 1);
            chk("underflow", underflow, (m_pos == frame_len(m_mode) - 1) && empty);
        end
        last_stb = (frame_stb === 1'b1);
        if (frame_stb === 1'b1) cnt_stb++;
        if (underflow === 1'b1) cnt_uf++;
        if (rst_n && din_valid && din_ready === 1'b1) cnt_xfer++;
        last_xfer = rst_n && din_valid && empty;
        if (!rst_n) begin
            m_hold.delete();
            m_csum  = 0;
            m_cur   = 0;
            m_pos   = 0;
            m_mode  = mode;
            m_vmod  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            nb     = ((m_csum + m_cur) >> 16) - (m_csum >> 16);
            m_csum = m_csum + m_cur;
            m_vmod = nb[0];
            if (m_pos == frame_len(m_mode) - 1) begin
                if (m_hold.size() != 0) m_cur = longint'(m_hold.pop_front());
                m_pos  = 0;
                m_mode = mode;
            end else begin
                m_pos++;
            end
            if (last_xfer) m_hold.push_back(din);
        end
        @(posedge clk);
        #1;
        if (vmod === 1'b1) cnt_ones++;
        if (b2b && last_xfer) din = din + 16'd1;
    endtask

    // Run one frame of n clocks, optionally pushing d on its first clock and
    // switching MODE at clock sw_at.
    task automatic frame_run(input int n, input logic push, input logic [15:0] d,
                             input int sw_at, input logic sw_mode);
        clr_counts();
        for (int i = 0; i < n; i++) begin
            if (i == 0 && push) begin
                din = d;
                din_valid = 1'b1;
            end
            if (i == sw_at) mode = sw_mode;
            cyc();
            din_valid = 1'b0;
            if (i == 0 && push) chk("ready_drop", din_ready, 1'b0);
        end
    endtask

    initial begin
        clr_counts();
        // Reset for 3 clocks
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_vmod",  vmod,      1'b0);
        chk("rst_ready", din_ready, 1'b1);
        chk("rst_stb",   frame_stb, 1'b0);
        chk("rst_uf",    underflow, 1'b0);
        rst_n = 1'b1;

        // Idle: two frames, strobes and underflows every 64 clocks, no ones
        clr_counts();
        repeat (128) cyc();
        chk("idle_stb",  cnt_stb,  2);
        chk("idle_uf",   cnt_uf,   2);
        chk("idle_ones", cnt_ones, 0);

        // F1: push 0x8000, no underflow at the boundary
        frame_run(64, 1'b1, 16'h8000, -1, 1'b0);
        chk("f1_uf",   cnt_uf,   0);
        chk("f1_stb",  last_stb, 1'b1);
        chk("f1_ones", cnt_ones, 0);
        // F2: cur=0x8000 -> 32 ones
        frame_run(64, 1'b1, 16'h4000, -1, 1'b0);
        chk("f2_ones", cnt_ones, 32);
        // F3, F4: cur=0x4000 -> 16 ones each
        frame_run(64, 1'b1, 16'h4000, -1, 1'b0);
        chk("f3_ones", cnt_ones, 16);
        frame_run(64, 1'b1, 16'h0000, -1, 1'b0);
        chk("f4_ones", cnt_ones, 16);
        // F5: cur=0 -> 0 ones; MODE switches mid-frame, frame stays 64
        frame_run(64, 1'b1, 16'h0400, 20, 1'b1);
        chk("f5_ones", cnt_ones, 0);
        chk("f5_len",  last_stb, 1'b1);
        chk("f5_nstb", cnt_stb,  1);
        // F6, F7: 256-clock frames with cur=0x0400 -> 4 ones each
        frame_run(256, 1'b1, 16'h0400, -1, 1'b1);
        chk("f6_ones", cnt_ones, 4);
        chk("f6_len",  last_stb, 1'b1);
        chk("f6_nstb", cnt_stb,  1);
        frame_run(256, 1'b0, 16'h0000, 100, 1'b0);
        chk("f7_ones", cnt_ones, 4);
        chk("f7_uf",   cnt_uf,   1);
        chk("f7_len",  last_stb, 1'b1);

        // Back-to-back source over six 64-clock frames
        clr_counts();
        din = 16'($urandom);
        din_valid = 1'b1;
        b2b = 1'b1;
        repeat (6 * 64) cyc();
        b2b = 1'b0;
        din_valid = 1'b0;
        chk("b2b_xfer", cnt_xfer, 6);
        chk("b2b_uf",   cnt_uf,   0);
        chk("b2b_stb",  cnt_stb,  6);

        // Mid-frame reset with hold full and cur=0x8000
        frame_run(64, 1'b1, 16'h8000, -1, 1'b0);
        din = 16'h1234;
        din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
        repeat (19) cyc();
        chk("pre_rst_ready", din_ready, 1'b0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mrst_vmod",  vmod,      1'b0);
        chk("mrst_ready", din_ready, 1'b1);
        chk("mrst_stb",   frame_stb, 1'b0);
        chk("mrst_uf",    underflow, 1'b0);
        frame_run(64, 1'b0, 16'h0000, -1, 1'b0);
        chk("mrst_ones", cnt_ones, 0);
        chk("mrst_uf_f", cnt_uf,   1);
        chk("mrst_len",  last_stb, 1'b1);
        chk("mrst_nstb", cnt_stb,  1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if (!din_valid || last_xfer) din = 16'($urandom);
            din_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 399) == 0) mode = ~mode;
            rst_n = ($urandom_range(0, 1499) != 0);
            cyc();
        end
        rst_n = 1'b1;
        din_valid = 1'b0;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
